// File: rtl/excess3_to_bcd_deserializer.sv
// Excess-3 to packed BCD deserializer.
// Accepts one Excess-3 digit per in_valid/in_ready beat, MSD first, decodes it
// to BCD (illegal codes become 0 and are flagged), and after DIGITS beats
// offers the assembled word downstream on an out_valid/out_ready handshake.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   digit handshake; in_xs3 is the Excess-3 digit
//   out_valid/out_ready word handshake
//   out_bcd             packed BCD word, first-accepted digit in the top nibble
//   out_err_mask        per-digit illegal flag, bit DIGITS-1 = first digit
//   out_err             OR of out_err_mask
module excess3_to_bcd_deserializer #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_xs3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err,
  output logic [DIGITS-1:0]     out_err_mask
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [W-1:0]    word, word_n;
  logic [DIGITS-1:0] mask, mask_n;

  logic            accept;
  logic            bad;
  logic [3:0]      digit;

  // Digit decode: legal Excess-3 codes are 3..12
  always_comb begin
    bad   = (in_xs3 < 4'h3) || (in_xs3 > 4'hC);
    digit = bad ? 4'h0 : (in_xs3 - 4'h3);
  end

  // Reset forces in_ready low combinationally so nothing is accepted on a reset edge
  assign in_ready = (state == COLLECT) && !rst;
  assign accept   = in_valid && in_ready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      cnt   <= '0;
      word  <= '0;
      mask  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      word  <= word_n;
      mask  <= mask_n;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    word_n  = word;
    mask_n  = mask;
    case (state)
      COLLECT: begin
        if (accept) begin
          word_n = (word << 4) | W'(digit);
          mask_n = (mask << 1) | DIGITS'(bad);
          if (cnt == CW'(DIGITS - 1)) begin
            cnt_n   = '0;
            state_n = FULL;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_n = COLLECT;
          word_n  = '0;
          mask_n  = '0;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  assign out_valid    = (state == FULL);
  assign out_bcd      = word;
  assign out_err_mask = mask;
  assign out_err      = |mask;

endmodule
